// File: rtl/fetch_queue_stage.sv
// Instruction fetch stage: sequential PC generation, credit-limited
// memory requests, in-order prefetch FIFO presented to decode.
module fetch_queue_stage #(
  parameter int XLEN = 32,
  parameter int ILEN = 32,
  parameter int DEPTH = 4,
  parameter int MAX_OUTSTANDING = 2,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [ILEN-1:0] NOP_INSTR = 32'h00000013
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            jump_enable,
  input  logic [XLEN-1:0] jump_address,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  output logic            valid_out,
  output logic [ILEN-1:0] instruction_out,
  output logic [XLEN-1:0] pc_out
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int SW = (MAX_OUTSTANDING > 1) ?
                      $clog2(MAX_OUTSTANDING) : 1;

  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] r_fifo_pc [DEPTH];
  logic [ILEN-1:0] r_fifo_data [DEPTH];
  logic [PW-1:0]   r_rd;
  logic [PW-1:0]   r_wr;
  logic [CW-1:0]   r_count;
  logic [OW-1:0]   r_out;
  logic [OW-1:0]   r_stale;
  logic [XLEN-1:0] r_sh_pc [MAX_OUTSTANDING];
  logic [SW-1:0]   r_sh_rd;
  logic [SW-1:0]   r_sh_wr;

  logic [31:0] w_used;
  logic        w_issue;
  logic        w_push;
  logic        w_pop;
  logic [OW-1:0] w_rsp_dec;

  function automatic logic [SW-1:0] sh_inc(input logic [SW-1:0] p);
    return (p == SW'(MAX_OUTSTANDING - 1)) ? '0 : p + SW'(1);
  endfunction

  // Credits cover queued entries plus live (non-stale) requests in flight
  assign w_used = 32'(r_count) + 32'(r_out) - 32'(r_stale);

  assign imem_req_valid = !reset && !jump_enable &&
                          (r_out < OW'(MAX_OUTSTANDING)) &&
                          (w_used < 32'(DEPTH));
  assign imem_req_addr  = r_fetch_pc;

  assign w_issue   = imem_req_valid && imem_req_ready;
  assign w_push    = imem_rsp_valid && (r_stale == '0) && !jump_enable;
  assign w_pop     = valid_out && !stall && !jump_enable;
  assign w_rsp_dec = OW'(imem_rsp_valid);

  assign valid_out       = (r_count != '0);
  assign instruction_out = valid_out ? r_fifo_data[r_rd] : NOP_INSTR;
  assign pc_out          = valid_out ? r_fifo_pc[r_rd] : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fetch_pc <= RESET_PC;
      r_rd       <= '0;
      r_wr       <= '0;
      r_count    <= '0;
      r_out      <= '0;
      r_stale    <= '0;
      r_sh_rd    <= '0;
      r_sh_wr    <= '0;
    end else if (jump_enable) begin
      r_fetch_pc <= {jump_address[XLEN-1:2], 2'b00};
      r_rd       <= '0;
      r_wr       <= '0;
      r_count    <= '0;
      r_out      <= r_out - w_rsp_dec;
      r_stale    <= r_out - w_rsp_dec;
      r_sh_rd    <= '0;
      r_sh_wr    <= '0;
    end else begin
      if (w_issue) begin
        r_fetch_pc <= r_fetch_pc + XLEN'(4);
        r_sh_wr    <= sh_inc(r_sh_wr);
      end
      if (w_push) begin
        r_wr    <= r_wr + PW'(1);
        r_sh_rd <= sh_inc(r_sh_rd);
      end
      if (w_pop)
        r_rd <= r_rd + PW'(1);
      if (imem_rsp_valid && (r_stale != '0))
        r_stale <= r_stale - OW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
      r_out   <= r_out + OW'(w_issue) - w_rsp_dec;
    end
  end

  always_ff @(posedge clk) begin
    if (w_issue)
      r_sh_pc[r_sh_wr] <= r_fetch_pc;
    if (w_push) begin
      r_fifo_pc[r_wr]   <= r_sh_pc[r_sh_rd];
      r_fifo_data[r_wr] <= imem_rsp_data;
    end
  end

endmodule

// File: tb/tb_fetch_queue_stage.sv
// Randomized bench for fetch_queue_stage against a queue-based
// model of the request/response stream and the prefetch queue.
module tb_fetch_queue_stage;

  localparam int DEPTH = 4;
  localparam int MAXO  = 2;
  localparam logic [31:0] RST_PC = 32'h0;
  localparam logic [31:0] NOP    = 32'h00000013;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        jump_enable = 1'b0;
  logic [31:0] jump_address = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        valid_out;
  logic [31:0] instruction_out;
  logic [31:0] pc_out;

  fetch_queue_stage #(
    .XLEN(32), .ILEN(32), .DEPTH(DEPTH),
    .MAX_OUTSTANDING(MAXO), .RESET_PC(RST_PC),
    .NOP_INSTR(NOP)
  ) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .jump_enable(jump_enable), .jump_address(jump_address),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data),
    .valid_out(valid_out),
    .instruction_out(instruction_out),
    .pc_out(pc_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
    int          ep;
    int          due;
  } req_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } ent_t;

  req_t pend[$];
  ent_t mq[$];
  logic [31:0] mpc;
  int epoch, cyc, last_due;
  int checks = 0;
  int failures = 0;
  int p_stall, p_jump, p_ready, lat_lo, lat_hi;
  bit f_jump;
  logic [31:0] f_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    pend.delete();
    mq.delete();
    mpc = RST_PC;
    epoch = 0;
    last_due = 0;
  endtask

  task automatic knobs(input int s, input int j, input int r,
                       input int lo, input int hi);
    p_stall = s; p_jump = j; p_ready = r;
    lat_lo = lo; lat_hi = hi;
  endtask

  task automatic step();
    req_t r;
    ent_t e;
    int stale;
    bit exp_rv, rsp, jmp, iss;
    int lat;
    @(negedge clk);
    stall = ($urandom_range(99) < p_stall);
    jmp = f_jump || ($urandom_range(99) < p_jump);
    jump_enable = jmp;
    jump_address = f_jump ? f_addr : $urandom;
    f_jump = 1'b0;
    imem_req_ready = ($urandom_range(99) < p_ready);
    rsp = (pend.size() > 0) && (pend[0].due <= cyc);
    imem_rsp_valid = rsp;
    imem_rsp_data = rsp ? pend[0].data : $urandom;
    #1;
    stale = 0;
    foreach (pend[i]) if (pend[i].ep != epoch) stale++;
    exp_rv = !jmp && (pend.size() < MAXO) &&
             ((mq.size() + pend.size() - stale) < DEPTH);
    chk("valid_out", 32'(valid_out), 32'(mq.size() > 0));
    chk("pc_out", pc_out, (mq.size() > 0) ? mq[0].pc : 32'h0);
    chk("instr_out", instruction_out,
        (mq.size() > 0) ? mq[0].data : NOP);
    chk("req_valid", 32'(imem_req_valid), 32'(exp_rv));
    if (exp_rv) chk("req_addr", imem_req_addr, mpc);
    iss = exp_rv && imem_req_ready;
    r = '{pc: 32'h0, data: 32'h0, ep: 0, due: 0};
    if (rsp) r = pend.pop_front();
    if (jmp) begin
      mq.delete();
      mpc = jump_address & ~32'h3;
      epoch++;
    end else begin
      if ((mq.size() > 0) && !stall) mq.delete(0);
      if (rsp && (r.ep == epoch)) begin
        e.pc = r.pc;
        e.data = r.data;
        mq.push_back(e);
      end
      if (iss) begin
        lat = $urandom_range(lat_hi, lat_lo);
        r.pc = mpc;
        r.data = mem_word(mpc);
        r.ep = epoch;
        r.due = cyc + lat;
        if (r.due <= last_due) r.due = last_due + 1;
        last_due = r.due;
        pend.push_back(r);
        mpc = mpc + 32'd4;
      end
    end
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    stall = 1'b0;
    jump_enable = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    #1;
    chk("rst_valid", 32'(valid_out), 32'h0);
    chk("rst_instr", instruction_out, NOP);
    chk("rst_pc", pc_out, 32'h0);
    chk("rst_req", 32'(imem_req_valid), 32'h0);
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    cyc = 0;
    f_jump = 1'b0;
    f_addr = '0;
    knobs(0, 0, 100, 1, 1);
    do_reset();
    // streaming, 1-cycle memory
    run(20);
    // long stall fills the queue, then drain
    knobs(100, 0, 100, 1, 1);
    run(20);
    knobs(0, 0, 100, 1, 1);
    run(12);
    // jump with two slow requests in flight
    knobs(0, 0, 100, 3, 3);
    run(6);
    f_jump = 1'b1;
    f_addr = 32'h00000103;
    run(15);
    // jump colliding with a response and a stall
    knobs(0, 0, 100, 1, 1);
    run(6);
    knobs(100, 0, 100, 1, 1);
    f_jump = 1'b1;
    f_addr = 32'hFFFFFFF9;
    run(1);
    knobs(0, 0, 100, 1, 1);
    run(12);
    // random ready, latency, stall and jumps
    knobs(30, 3, 50, 1, 4);
    run(200);
    // reset with the queue partly filled
    knobs(0, 0, 100, 1, 1);
    run(6);
    knobs(100, 0, 100, 1, 1);
    run(3);
    do_reset();
    knobs(0, 0, 100, 1, 1);
    run(12);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_queue_stage.md
Name: fetch_queue_stage

Overview:
Parametrised instruction-fetch stage with a decoupled, variable-latency instruction-memory interface and an in-order prefetch queue. It generates sequential PCs and issues up to MAX_OUTSTANDING requests, buffering returned instructions with their PCs in a DEPTH-entry FIFO. It presents the head entry to decode under a stall/valid handshake. A jump flushes the queue, retargets the PC and squashes in-flight responses without waiting for them.

Parameters:
XLEN, 32, address/PC width
ILEN, 32, instruction width
DEPTH, 4, prefetch FIFO entries (power of two, >= 2)
MAX_OUTSTANDING, 2, max issued-but-unreturned requests (>= 1, <= DEPTH)
RESET_PC, 0, PC after reset
NOP_INSTR, 32'h00000013, instruction shown when output invalid

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
stall  in  1  decode cannot accept; head entry held
jump_enable  in  1  redirect/flush this cycle
jump_address  in  XLEN  redirect target; bits [1:0] forced to 0
imem_req_valid  out  1  request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  XLEN  request address (= fetch PC)
imem_rsp_valid  in  1  response valid; in order, always accepted
imem_rsp_data  in  ILEN  returned instruction
valid_out  out  1  head entry valid
instruction_out  out  ILEN  head instruction; NOP_INSTR when !valid_out
pc_out  out  XLEN  head PC; 0 when !valid_out

Behaviour:
- State: fetch_pc, FIFO (rd/wr pointers + count), outstanding counter, stale counter (both clog2(MAX_OUTSTANDING+1) bits).
- Reset (async): fetch_pc=RESET_PC; FIFO empty; outstanding=stale=0; valid_out=0, instruction_out=NOP_INSTR, pc_out=0, imem_req_valid=0. The memory shares the reset, so no pre-reset response may arrive afterwards.
- Issue: imem_req_valid = !jump_enable && outstanding < MAX_OUTSTANDING && (count + outstanding - stale) < DEPTH. This credit rule guarantees the FIFO never overflows. imem_req_addr = fetch_pc. Handshake (valid&&ready): fetch_pc += 4 (wraps mod 2^XLEN), outstanding++.
- Response: each imem_rsp_valid decrements outstanding. If stale>0, data is dropped and stale decrements. Otherwise {pc, data} is pushed. The pushed PC comes from a PC shadow FIFO of MAX_OUTSTANDING entries written at issue. Minimum latency is 1 cycle after request handshake; a response is visible at the output the cycle after it is pushed.
- Output: combinational from FIFO head. Pop when valid_out && !stall. Push and pop in the same cycle are legal at any count, including full.
- Jump (highest priority, overrides stall): FIFO emptied, shadow PC FIFO emptied, fetch_pc = {jump_address[XLEN-1:2],2'b00}. All currently unreturned requests become stale: stale_next = outstanding - (rsp_valid this cycle). A response arriving in the jump cycle is discarded. No request is issued in the jump cycle. valid_out may be 1 during the jump cycle (the pre-flush head); it is 0 from the next cycle until the new stream returns.
- Back-to-back jumps: each recomputes stale from the current outstanding count; the last target wins.
- Stall held indefinitely: the FIFO fills to DEPTH and issue stops. Issue resumes the cycle after a pop frees a credit.
- imem_req_ready low: request and address held stable; fetch_pc unchanged.
- Zero-bubble: with 1-cycle memory and no stall, throughput is 1 instr/cycle after initial fill.

Test Plan:
- Reset, memory ready with 1-cycle latency, stall=0 -> requests 0x0,0x4,0x8,...; first valid_out at cycle 3 with pc_out=0x0; then one instruction per cycle in PC order.
- stall=1 from cycle 2 for 20 cycles -> FIFO holds 4 entries (PCs 0x0..0xC), imem_req_valid=0 once credits are exhausted, output stable. Releasing stall drains in order with no loss or duplication.
- Memory latency 3, MAX_OUTSTANDING=2, jump to 0x103 while 2 requests are in flight -> both old responses dropped; next request addr 0x100; first valid_out shows pc_out=0x100.
- Jump in the same cycle as a response and as stall=1 -> response discarded, FIFO empty next cycle, stale equals the remaining outstanding count, new fetch at the jump target.
- imem_req_ready toggling 0/1 randomly for 200 cycles with random latency 1–4 and random stall -> output PC sequence strictly +4 and data matches the memory model. FIFO count never exceeds DEPTH; outstanding never exceeds MAX_OUTSTANDING.
- Assert reset mid-burst with FIFO half full -> outputs return to reset values immediately; after release, fetch restarts at RESET_PC.
